instr_decode_stage: RTL and testbench
=====================================

INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- valid_in  in  1  IF/ID holds a real instruction
- instr_in  in  32  IF/ID instruction word
- pc_plus4_in  in  32  IF/ID PC+4
- flush  in  1  squash the instruction in ID (taken branch/jump resolved downstream)
- rs_num  out  5  register-file first read number
- rt_num  out  5  register-file second read number
- stall_out  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  ID/EX holds a real instruction
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch_eq, ex_branch_ne, ex_jump, ex_jal  out  1 each  registered control
- ex_alu_op  out  4  ALU function: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 slt, 7 sll, 8 srl, 9 sra, 10 lui
- ex_write_reg  out  5  destination register number
- ex_imm  out  32  extended immediate
- ex_shamt  out  5  shift amount
- ex_jtarget  out  26  jump index field
- ex_pc_plus4  out  32  registered PC+4
- ex_illegal  out  1  one-cycle pulse: unsupported opcode/funct decoded

Function
REQ-003 rs_num SHALL equal instr_in[25:21] and rt_num SHALL equal instr_in[20:16], combinationally, so the register file's one-cycle registered read lines up with the ID/EX outputs.
REQ-004 ID/EX outputs SHALL update on every rising edge: either the decoded instruction or a bubble; latency exactly 1 cycle.
REQ-005 Supported set: R-type add, addu, sub, subu, and, or, xor, nor, slt, sll, srl, sra, jr; I-type addi, addiu, andi, ori, xori, slti, lui, lw, sw, beq, bne; J-type j, jal; anything else SHALL be illegal.
REQ-006 ex_write_reg SHALL be rd for R-type, rt for I-type ALU and lw, 31 for jal, 0 otherwise; ex_reg_write SHALL be 0 whenever ex_write_reg is 0.
REQ-007 ex_imm SHALL be sign-extended for addi, addiu, slti, lw, sw, beq, bne; zero-extended for andi, ori, xori; instr_in[15:0]<<16 for lui.
REQ-008 addu/addiu SHALL map to alu_op add and subu to sub; jr SHALL set ex_jump=1 with ex_alu_src=0; jal SHALL set ex_jump=1 and ex_jal=1.
REQ-009 Bubble = ex_valid and all control outputs 0, ex_alu_op, ex_write_reg, ex_imm, ex_shamt, ex_jtarget 0; ex_pc_plus4 still loaded.
REQ-010 A bubble SHALL be loaded when valid_in=0, flush=1, stall_out=1, or the instruction is illegal.
REQ-011 ex_illegal SHALL be 1 for exactly the cycle after an illegal instruction with valid_in=1 and flush=0 is in ID.
REQ-012 flush SHALL take priority over stall: stall_out=0 whenever flush=1.
REQ-013 Load-use hazard: stall_out=1 when valid_in=1, flush=0, ex_valid=1, ex_mem_read=1, ex_write_reg!=0, and ex_write_reg equals rs_num (if rs is read) or rt_num (if rt is read: R-type, sw, beq, bne).
REQ-014 A single load-use hazard SHALL stall exactly one cycle, since the inserted bubble clears ex_mem_read.

Reset
REQ-015 While rst_n=0 at a rising edge, all registered outputs SHALL become 0 (bubble, ex_pc_plus4=0, ex_illegal=0).
REQ-016 stall_out SHALL be 0 in the cycle after reset regardless of instr_in; reset mid-stall SHALL drop the stall.

Configuration
REQ-017 With macro HAZARD_DETECT_EN defined, REQ-013/REQ-014 apply; without it, stall_out SHALL be tied to 0 and no hazard comparison logic is built (software inserts nops).

Verification
REQ-018 Bench SHALL cover:
- add $3,$1,$2 (0x00221820) valid -> next cycle ex_valid=1, ex_reg_write=1, ex_alu_op=0, ex_write_reg=3; rs_num=1, rt_num=2 same cycle.
- ori $4,$0,0x8000 -> ex_imm=0x00008000; addi $4,$0,-1 -> ex_imm=0xFFFFFFFF; lui $5,0x1234 -> ex_imm=0x12340000, ex_alu_op=10.
- lw $2,0($1) then add $3,$2,$2 -> stall_out=1 for one cycle, one bubble, then add decodes (with HAZARD_DETECT_EN); without macro stall_out stays 0.
- lw $0,0($1) then add $3,$0,$0 -> no stall; jal -> ex_write_reg=31, ex_jal=1.
- flush=1 during a load-use hazard -> stall_out=0, bubble loaded; opcode 0x3F -> ex_illegal pulses 1 cycle, bubble.
- rst_n=0 mid-stream -> all outputs 0 next edge, stall_out=0.

Source files
------------

// File: rtl/instr_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decode_stage
//  Description : MIPS-subset instruction decode stage. Decodes the IF/ID word
//                into ID/EX control, immediate and register-number fields,
//                inserts bubbles for invalid, flushed, illegal or stalled
//                instructions, and (optionally) detects load-use hazards.
//  Options     : define HAZARD_DETECT_EN to build the load-use stall logic;
//                without it stall_out is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  input  logic        flush,
  output logic [4:0]  rs_num,
  output logic [4:0]  rt_num,
  output logic        stall_out,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic        ex_alu_src,
  output logic        ex_branch_eq,
  output logic        ex_branch_ne,
  output logic        ex_jump,
  output logic        ex_jal,
  output logic [3:0]  ex_alu_op,
  output logic [4:0]  ex_write_reg,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_shamt,
  output logic [25:0] ex_jtarget,
  output logic [31:0] ex_pc_plus4,
  output logic        ex_illegal
);

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // ALU function encoding seen by EX
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_SRA = 4'd9;
  localparam logic [3:0] ALU_LUI = 4'd10;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rd_num;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] imm_lui;

  assign opcode   = instr_in[31:26];
  assign funct    = instr_in[5:0];
  assign rd_num   = instr_in[15:11];
  assign imm_sext = {{16{instr_in[15]}}, instr_in[15:0]};
  assign imm_zext = {16'h0000, instr_in[15:0]};
  assign imm_lui  = {instr_in[15:0], 16'h0000};

  // Register-file read numbers go out unregistered so the RF's own read
  // register lines up with the ID/EX outputs.
  assign rs_num = instr_in[25:21];
  assign rt_num = instr_in[20:16];

  logic        dec_reg_write;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        dec_mem_to_reg;
  logic        dec_alu_src;
  logic        dec_branch_eq;
  logic        dec_branch_ne;
  logic        dec_jump;
  logic        dec_jal;
  logic [3:0]  dec_alu_op;
  logic [4:0]  dec_write_reg;
  logic [31:0] dec_imm;
  logic [4:0]  dec_shamt;
  logic [25:0] dec_jtarget;
  logic        dec_illegal;

  // Main decoder: the instruction in ID mapped onto ID/EX fields.
  always_comb begin
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_alu_src    = 1'b0;
    dec_branch_eq  = 1'b0;
    dec_branch_ne  = 1'b0;
    dec_jump       = 1'b0;
    dec_jal        = 1'b0;
    dec_alu_op     = ALU_ADD;
    dec_write_reg  = 5'd0;
    dec_imm        = 32'd0;
    dec_shamt      = 5'd0;
    dec_jtarget    = 26'd0;
    dec_illegal    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_write_reg = rd_num;
        case (funct)
          FN_ADD, FN_ADDU: dec_alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: dec_alu_op = ALU_SUB;
          FN_AND:          dec_alu_op = ALU_AND;
          FN_OR:           dec_alu_op = ALU_OR;
          FN_XOR:          dec_alu_op = ALU_XOR;
          FN_NOR:          dec_alu_op = ALU_NOR;
          FN_SLT:          dec_alu_op = ALU_SLT;
          FN_SLL: begin
            dec_alu_op = ALU_SLL;
            dec_shamt  = instr_in[10:6];
          end
          FN_SRL: begin
            dec_alu_op = ALU_SRL;
            dec_shamt  = instr_in[10:6];
          end
          FN_SRA: begin
            dec_alu_op = ALU_SRA;
            dec_shamt  = instr_in[10:6];
          end
          FN_JR: begin
            dec_write_reg = 5'd0;
            dec_jump      = 1'b1;
          end
          default: begin
            dec_write_reg = 5'd0;
            dec_illegal   = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        dec_alu_src   = 1'b1;
        dec_write_reg = rt_num;
        dec_imm       = imm_sext;
      end
      OP_SLTI: begin
        dec_alu_src   = 1'b1;
        dec_alu_op    = ALU_SLT;
        dec_write_reg = rt_num;
        dec_imm       = imm_sext;
      end
      OP_ANDI: begin
        dec_alu_src   = 1'b1;
        dec_alu_op    = ALU_AND;
        dec_write_reg = rt_num;
        dec_imm       = imm_zext;
      end
      OP_ORI: begin
        dec_alu_src   = 1'b1;
        dec_alu_op    = ALU_OR;
        dec_write_reg = rt_num;
        dec_imm       = imm_zext;
      end
      OP_XORI: begin
        dec_alu_src   = 1'b1;
        dec_alu_op    = ALU_XOR;
        dec_write_reg = rt_num;
        dec_imm       = imm_zext;
      end
      OP_LUI: begin
        dec_alu_src   = 1'b1;
        dec_alu_op    = ALU_LUI;
        dec_write_reg = rt_num;
        dec_imm       = imm_lui;
      end
      OP_LW: begin
        dec_alu_src    = 1'b1;
        dec_mem_read   = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_write_reg  = rt_num;
        dec_imm        = imm_sext;
      end
      OP_SW: begin
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
        dec_imm       = imm_sext;
      end
      OP_BEQ: begin
        dec_alu_op    = ALU_SUB;
        dec_branch_eq = 1'b1;
        dec_imm       = imm_sext;
      end
      OP_BNE: begin
        dec_alu_op    = ALU_SUB;
        dec_branch_ne = 1'b1;
        dec_imm       = imm_sext;
      end
      OP_J: begin
        dec_jump    = 1'b1;
        dec_jtarget = instr_in[25:0];
      end
      OP_JAL: begin
        dec_jump      = 1'b1;
        dec_jal       = 1'b1;
        dec_write_reg = 5'd31;
        dec_jtarget   = instr_in[25:0];
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // A write to $0 is never a real write, so reg_write follows the target.
  assign dec_reg_write = (dec_write_reg != 5'd0);

`ifdef HAZARD_DETECT_EN
  logic uses_rs;
  logic uses_rt;

  // Which source fields the instruction in ID actually reads.
  always_comb begin
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        uses_rt = 1'b1;
        uses_rs = !((funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA));
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LW: uses_rs = 1'b1;
      default: begin
        uses_rs = 1'b0;
        uses_rt = 1'b0;
      end
    endcase
  end

  // Load-use: the load in EX has not produced its data yet. Flush and reset
  // both suppress the stall; illegal words read nothing.
  assign stall_out = rst_n && valid_in && !flush && !dec_illegal &&
                     ex_valid && ex_mem_read && (ex_write_reg != 5'd0) &&
                     ((uses_rs && (ex_write_reg == rs_num)) ||
                      (uses_rt && (ex_write_reg == rt_num)));
`else
  // Software schedules around load-use hazards in this build.
  assign stall_out = 1'b0;
`endif

  logic load_instr;
  assign load_instr = valid_in && !flush && !stall_out && !dec_illegal;

  // ID/EX pipeline register: decoded instruction or bubble every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_branch_eq  <= 1'b0;
      ex_branch_ne  <= 1'b0;
      ex_jump       <= 1'b0;
      ex_jal        <= 1'b0;
      ex_alu_op     <= 4'd0;
      ex_write_reg  <= 5'd0;
      ex_imm        <= 32'd0;
      ex_shamt      <= 5'd0;
      ex_jtarget    <= 26'd0;
      ex_pc_plus4   <= 32'd0;
      ex_illegal    <= 1'b0;
    end else begin
      ex_pc_plus4   <= pc_plus4_in;
      ex_illegal    <= valid_in && !flush && dec_illegal;
      ex_valid      <= load_instr;
      ex_reg_write  <= load_instr && dec_reg_write;
      ex_mem_read   <= load_instr && dec_mem_read;
      ex_mem_write  <= load_instr && dec_mem_write;
      ex_mem_to_reg <= load_instr && dec_mem_to_reg;
      ex_alu_src    <= load_instr && dec_alu_src;
      ex_branch_eq  <= load_instr && dec_branch_eq;
      ex_branch_ne  <= load_instr && dec_branch_ne;
      ex_jump       <= load_instr && dec_jump;
      ex_jal        <= load_instr && dec_jal;
      ex_alu_op     <= load_instr ? dec_alu_op    : 4'd0;
      ex_write_reg  <= load_instr ? dec_write_reg : 5'd0;
      ex_imm        <= load_instr ? dec_imm       : 32'd0;
      ex_shamt      <= load_instr ? dec_shamt     : 5'd0;
      ex_jtarget    <= load_instr ? dec_jtarget   : 26'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_decode_stage
//  Description : Self-checking bench for instr_decode_stage. A mnemonic-level
//                reference model predicts every output; directed sequences
//                cover the named cases, then randomized traffic follows.
//  Options     : honours HAZARD_DETECT_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_decode_stage;

`ifdef HAZARD_DETECT_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] instr_in = 32'd0;
  logic [31:0] pc_plus4_in = 32'd0;
  logic        flush = 1'b0;
  logic [4:0]  rs_num, rt_num;
  logic        stall_out, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_mem_to_reg, ex_alu_src, ex_branch_eq, ex_branch_ne, ex_jump, ex_jal;
  logic [3:0]  ex_alu_op;
  logic [4:0]  ex_write_reg, ex_shamt;
  logic [31:0] ex_imm, ex_pc_plus4;
  logic [25:0] ex_jtarget;
  logic        ex_illegal;

  instr_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .instr_in(instr_in),
    .pc_plus4_in(pc_plus4_in), .flush(flush), .rs_num(rs_num), .rt_num(rt_num),
    .stall_out(stall_out), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src),
    .ex_branch_eq(ex_branch_eq), .ex_branch_ne(ex_branch_ne), .ex_jump(ex_jump),
    .ex_jal(ex_jal), .ex_alu_op(ex_alu_op), .ex_write_reg(ex_write_reg),
    .ex_imm(ex_imm), .ex_shamt(ex_shamt), .ex_jtarget(ex_jtarget),
    .ex_pc_plus4(ex_pc_plus4), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  typedef enum int {
    M_ILL, M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT,
    M_SLL, M_SRL, M_SRA, M_JR,
    M_ADDI, M_ADDIU, M_ANDI, M_ORI, M_XORI, M_SLTI, M_LUI, M_LW,
    M_SW, M_BEQ, M_BNE, M_J, M_JAL
  } mn_t;

  typedef struct {
    logic        valid, reg_write, mem_read, mem_write, mem_to_reg, alu_src;
    logic        beq, bne, jump, jal, illegal;
    logic [3:0]  alu_op;
    logic [4:0]  wr, shamt;
    logic [31:0] imm, pc4;
    logic [25:0] jt;
    logic        reads_rs, reads_rt;
  } ex_t;

  int   n_vec = 0;
  int   n_err = 0;
  ex_t  mex;               // model's view of the ID/EX register
  logic last_stall = 1'b0; // model's stall for the most recent cycle
  logic [31:0] pc_ctr = 32'h0000_1004;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic mn_t classify(input logic [31:0] w);
    mn_t m;
    m = M_ILL;
    case (w[31:26])
      6'h00: case (w[5:0])
        6'h20: m = M_ADD;  6'h21: m = M_ADDU; 6'h22: m = M_SUB;  6'h23: m = M_SUBU;
        6'h24: m = M_AND;  6'h25: m = M_OR;   6'h26: m = M_XOR;  6'h27: m = M_NOR;
        6'h2A: m = M_SLT;  6'h00: m = M_SLL;  6'h02: m = M_SRL;  6'h03: m = M_SRA;
        6'h08: m = M_JR;   default: m = M_ILL;
      endcase
      6'h08: m = M_ADDI; 6'h09: m = M_ADDIU; 6'h0C: m = M_ANDI; 6'h0D: m = M_ORI;
      6'h0E: m = M_XORI; 6'h0A: m = M_SLTI;  6'h0F: m = M_LUI;  6'h23: m = M_LW;
      6'h2B: m = M_SW;   6'h04: m = M_BEQ;   6'h05: m = M_BNE;  6'h02: m = M_J;
      6'h03: m = M_JAL;  default: m = M_ILL;
    endcase
    return m;
  endfunction

  // What the instruction would put in ID/EX if it were loaded.
  function automatic ex_t decode_ref(input logic [31:0] w);
    ex_t e;
    mn_t m;
    logic rtype;
    e = '{default: '0};
    m = classify(w);
    rtype = (w[31:26] == 6'h00) && (m != M_ILL);
    e.valid   = 1'b1;
    e.illegal = (m == M_ILL);
    case (m)
      M_SUB, M_SUBU, M_BEQ, M_BNE: e.alu_op = 4'd1;
      M_AND, M_ANDI: e.alu_op = 4'd2;
      M_OR, M_ORI:   e.alu_op = 4'd3;
      M_XOR, M_XORI: e.alu_op = 4'd4;
      M_NOR:         e.alu_op = 4'd5;
      M_SLT, M_SLTI: e.alu_op = 4'd6;
      M_SLL:         e.alu_op = 4'd7;
      M_SRL:         e.alu_op = 4'd8;
      M_SRA:         e.alu_op = 4'd9;
      M_LUI:         e.alu_op = 4'd10;
      default:       e.alu_op = 4'd0;
    endcase
    if (rtype && m != M_JR)          e.wr = w[15:11];
    else if (m >= M_ADDI && m <= M_LW) e.wr = w[20:16];
    else if (m == M_JAL)             e.wr = 5'd31;
    e.reg_write  = (e.wr != 5'd0);
    e.mem_read   = (m == M_LW);
    e.mem_to_reg = (m == M_LW);
    e.mem_write  = (m == M_SW);
    e.alu_src    = (m >= M_ADDI && m <= M_SW);
    e.beq        = (m == M_BEQ);
    e.bne        = (m == M_BNE);
    e.jump       = (m == M_JR) || (m == M_J) || (m == M_JAL);
    e.jal        = (m == M_JAL);
    if (m == M_ADDI || m == M_ADDIU || m == M_SLTI || m == M_LW || m == M_SW ||
        m == M_BEQ || m == M_BNE)
      e.imm = 32'(signed'(w[15:0]));
    else if (m == M_ANDI || m == M_ORI || m == M_XORI)
      e.imm = {16'd0, w[15:0]};
    else if (m == M_LUI)
      e.imm = {w[15:0], 16'd0};
    if (m == M_SLL || m == M_SRL || m == M_SRA) e.shamt = w[10:6];
    if (m == M_J || m == M_JAL) e.jt = w[25:0];
    e.reads_rs = !(m == M_ILL || m == M_LUI || m == M_J || m == M_JAL ||
                   m == M_SLL || m == M_SRL || m == M_SRA);
    e.reads_rt = rtype || m == M_SW || m == M_BEQ || m == M_BNE;
    return e;
  endfunction

  // One clock: drive at negedge, check combinational outputs, then check the
  // registered outputs just after the rising edge.
  task automatic cycle(input logic v, input logic [31:0] w, input logic fl,
                       input logic rn, input logic [31:0] pc);
    ex_t d, nx;
    logic st;
    @(negedge clk);
    valid_in = v; instr_in = w; flush = fl; rst_n = rn; pc_plus4_in = pc;
    #1;
    d  = decode_ref(w);
    st = HZ && rn && v && !fl && mex.valid && mex.mem_read && (mex.wr != 5'd0) &&
         ((d.reads_rs && mex.wr == w[25:21]) || (d.reads_rt && mex.wr == w[20:16]));
    check("rs_num", 64'(rs_num), 64'(w[25:21]));
    check("rt_num", 64'(rt_num), 64'(w[20:16]));
    check("stall_out", 64'(stall_out), 64'(st));
    last_stall = st;
    @(posedge clk);
    #1;
    nx = '{default: '0};
    if (rn) begin
      nx.pc4     = pc;
      nx.illegal = v && !fl && d.illegal;
      if (v && !fl && !st && !d.illegal) begin
        nx = d;
        nx.pc4 = pc;
        nx.illegal = 1'b0;
      end
    end
    mex = nx;
    check("ctrl", 64'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                       ex_alu_src, ex_branch_eq, ex_branch_ne, ex_jump, ex_jal}),
                  64'({mex.valid, mex.reg_write, mex.mem_read, mex.mem_write, mex.mem_to_reg,
                       mex.alu_src, mex.beq, mex.bne, mex.jump, mex.jal}));
    check("alu_op", 64'(ex_alu_op), 64'(mex.alu_op));
    check("write_reg", 64'(ex_write_reg), 64'(mex.wr));
    check("imm", 64'(ex_imm), 64'(mex.imm));
    check("shamt", 64'(ex_shamt), 64'(mex.shamt));
    check("jtarget", 64'(ex_jtarget), 64'(mex.jt));
    check("pc_plus4", 64'(ex_pc_plus4), 64'(mex.pc4));
    check("illegal", 64'(ex_illegal), 64'(mex.illegal));
  endtask

  // Issue one instruction, holding it (as IF/ID would) while stalled.
  task automatic issue(input logic [31:0] w, output int nstall);
    logic [31:0] pc;
    pc = pc_ctr;
    pc_ctr += 4;
    nstall = 0;
    cycle(1'b1, w, 1'b0, 1'b1, pc);
    while (last_stall && nstall < 4) begin
      nstall++;
      cycle(1'b1, w, 1'b0, 1'b1, pc);
    end
  endtask

  function automatic logic [31:0] gen_instr();
    int k;
    logic [4:0] rs, rt, rd, sh;
    logic [15:0] imm;
    logic [5:0] op, fn;
    k   = $urandom_range(0, 27);
    rs  = 5'($urandom_range(0, 3));
    rt  = 5'($urandom_range(0, 3));
    rd  = 5'($urandom_range(0, 3));
    sh  = 5'($urandom);
    imm = 16'($urandom);
    op = 6'h00; fn = 6'h20;
    case (k)
      0: fn = 6'h20;  1: fn = 6'h21;  2: fn = 6'h22;  3: fn = 6'h23;
      4: fn = 6'h24;  5: fn = 6'h25;  6: fn = 6'h26;  7: fn = 6'h27;
      8: fn = 6'h2A;  9: fn = 6'h00;  10: fn = 6'h02; 11: fn = 6'h03;
      12: fn = 6'h08; 13: op = 6'h08; 14: op = 6'h09; 15: op = 6'h0A;
      16: op = 6'h0C; 17: op = 6'h0D; 18: op = 6'h0E; 19: op = 6'h0F;
      20: op = 6'h23; 21: op = 6'h2B; 22: op = 6'h04; 23: op = 6'h05;
      24: op = 6'h02; 25: op = 6'h03;
      26: return $urandom;
      default: return {6'h3F, 26'($urandom)};
    endcase
    if (k <= 12) return {6'h00, rs, rt, rd, sh, fn};
    return {op, rs, rt, imm};
  endfunction

  initial begin
    int ns;
    logic hv, fl, rn;
    logic [31:0] hi, hp;
    mex = '{default: '0};

    // Reset state
    cycle(1'b1, 32'h00221820, 1'b0, 1'b0, 32'h4);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h8);
    check("rst_valid", 64'(ex_valid), 64'd0);

    // add $3,$1,$2
    issue(32'h00221820, ns);
    check("add_valid", 64'(ex_valid), 64'd1);
    check("add_rw", 64'(ex_reg_write), 64'd1);
    check("add_op", 64'(ex_alu_op), 64'd0);
    check("add_wr", 64'(ex_write_reg), 64'd3);

    // Immediate forms
    issue(32'h34048000, ns);
    check("ori_imm", 64'(ex_imm), 64'h0000_8000);
    issue(32'h2004FFFF, ns);
    check("addi_imm", 64'(ex_imm), 64'hFFFF_FFFF);
    issue(32'h3C051234, ns);
    check("lui_imm", 64'(ex_imm), 64'h1234_0000);
    check("lui_op", 64'(ex_alu_op), 64'd10);

    // Load-use: lw $2 then add $3,$2,$2
    issue(32'h8C220000, ns);
    issue(32'h00421820, ns);
    check("lu_stalls", 64'(ns), HZ ? 64'd1 : 64'd0);
    check("lu_add_wr", 64'(ex_write_reg), 64'd3);

    // lw to $0 never stalls
    issue(32'h8C200000, ns);
    issue(32'h00001820, ns);
    check("lw0_stalls", 64'(ns), 64'd0);

    // jal
    issue(32'h0C000100, ns);
    check("jal_wr", 64'(ex_write_reg), 64'd31);
    check("jal_flag", 64'(ex_jal), 64'd1);

    // Flush beats a pending load-use stall
    issue(32'h8C220000, ns);
    cycle(1'b1, 32'h00421820, 1'b1, 1'b1, pc_ctr);
    pc_ctr += 4;
    check("flush_stall", 64'(last_stall), 64'd0);
    check("flush_bubble", 64'(ex_valid), 64'd0);

    // Illegal opcode pulses once
    cycle(1'b1, 32'hFC000000, 1'b0, 1'b1, pc_ctr);
    check("ill_pulse", 64'(ex_illegal), 64'd1);
    check("ill_bubble", 64'(ex_valid), 64'd0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, pc_ctr);
    check("ill_clear", 64'(ex_illegal), 64'd0);

    // Reset mid-stall
    issue(32'h8C220000, ns);
    cycle(1'b1, 32'h00421820, 1'b0, 1'b0, pc_ctr);
    check("rst_pc4", 64'(ex_pc_plus4), 64'd0);
    check("rst_mr", 64'(ex_mem_read), 64'd0);
    cycle(1'b1, 32'h00421820, 1'b0, 1'b1, pc_ctr);
    check("rst_nostall", 64'(last_stall), 64'd0);

    // Randomized traffic
    hv = 1'b0; hi = 32'd0; hp = 32'd0;
    for (int i = 0; i < 1500; i++) begin
      if (!last_stall) begin
        hv = ($urandom_range(0, 7) != 0);
        hi = gen_instr();
        hp = pc_ctr;
        pc_ctr += 4;
      end
      fl = ($urandom_range(0, 11) == 0);
      rn = ($urandom_range(0, 199) != 0);
      cycle(hv, hi, fl, rn, hp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
